// File: rtl/exec_pkg.sv
// Shared types for the execute-stage sequencing controller: FSM states,
// instruction-class priority encoding and CPSR flag bit positions.
package exec_pkg;

    typedef enum logic [1:0] {StIdle, StWb, StMemWait, StFlush} exec_state_e;

    typedef enum logic [2:0] {OpNop, OpAlu, OpCmp, OpJmp, OpProc, OpStr, OpLd} op_class_e;

    localparam int unsigned CpsrN = 3;
    localparam int unsigned CpsrZ = 2;
    localparam int unsigned CpsrC = 1;
    localparam int unsigned CpsrV = 0;

    // Highest-priority class wins when decode asserts several class bits.
    function automatic op_class_e decode_class(input logic ld, input logic str,
                                               input logic proc, input logic jmp,
                                               input logic cmp, input logic alu);
        if (ld)   return OpLd;
        if (str)  return OpStr;
        if (proc) return OpProc;
        if (jmp)  return OpJmp;
        if (cmp)  return OpCmp;
        if (alu)  return OpAlu;
        return OpNop;
    endfunction

endpackage

// File: rtl/exec_mem_seq.sv
// Memory request/acknowledge sequencing for MEM_WAIT, with an optional
// no-ack abort enabled by EXEC_MEM_TIMEOUT_EN.
module exec_mem_seq #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic in_wait,
    input  logic mem_ack,
    output logic mem_req,
    output logic ack_seen,
    output logic timeout,
    output logic mem_err
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
`ifdef EXEC_MEM_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            mem_err_q;

    // Counter sits at zero outside MEM_WAIT, so it is clear on every entry.
    always_comb begin
        mem_req  = in_wait;
        ack_seen = in_wait & mem_ack;
        cnt_d    = in_wait ? cnt_q + CntW'(1) : '0;
        timeout  = TimeoutEn & in_wait & ~mem_ack & (cnt_q == CntW'(MEM_TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mem_err_q <= timeout;
        end
    end

    assign mem_err = mem_err_q;

endmodule

// File: rtl/exec_ctrl.sv
// Execute-stage sequencing controller: owns CPSR flags and schedules writeback,
// PC redirect/flush and memory access per instruction. Optional: EXEC_MEM_TIMEOUT_EN.
module exec_ctrl
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              is_alu_op,
    input  logic              is_cmp_op,
    input  logic              is_jmp_op,
    input  logic              is_ld_op,
    input  logic              is_str_op,
    input  logic              is_proc_op,
    input  logic [3:0]        rd_num,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] rd_val,
    input  logic [3:0]        nzcv_in,
    input  logic              taken,
    input  logic [DATA_W-1:0] md32,
    output logic [DATA_W-1:0] cpsr_out,
    output logic              reg_we,
    output logic [3:0]        reg_waddr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              pc_we,
    output logic [DATA_W-1:0] pc_target,
    output logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_err,
    output logic              busy
);

    exec_state_e       state_q, state_d;
    op_class_e         op;
    logic              accept;
    logic              mem_wait, ack_seen, timeout;
    logic [3:0]        nzcv_q, rd_q;
    logic [DATA_W-1:0] addr_q, st_data_q, target_q, wb_data_q;
    logic              is_st_q;

    assign op       = decode_class(is_ld_op, is_str_op, is_proc_op, is_jmp_op, is_cmp_op,
                                   is_alu_op);
    assign in_ready = (state_q == StIdle);
    assign accept   = in_valid & in_ready;
    assign mem_wait = (state_q == StMemWait);

    exec_mem_seq #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_seq (
        .clk     (clk),
        .reset   (reset),
        .in_wait (mem_wait),
        .mem_ack (mem_ack),
        .mem_req (mem_req),
        .ack_seen(ack_seen),
        .timeout (timeout),
        .mem_err (mem_err)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (op)
                        OpAlu:       state_d = StWb;
                        OpJmp:       state_d = taken ? StFlush : StIdle;
                        OpProc:      state_d = StFlush;
                        OpLd, OpStr: state_d = StMemWait;
                        default:     state_d = StIdle;
                    endcase
                end
            end
            StWb:    state_d = StIdle;
            StFlush: state_d = StIdle;
            StMemWait: begin
                // A same-cycle ack beats the timeout.
                if (ack_seen)     state_d = is_st_q ? StIdle : StWb;
                else if (timeout) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            nzcv_q    <= '0;
            rd_q      <= '0;
            addr_q    <= '0;
            st_data_q <= '0;
            target_q  <= '0;
            wb_data_q <= '0;
            is_st_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rd_q      <= rd_num;
                addr_q    <= alu_result;
                st_data_q <= rd_val;
                target_q  <= md32;
                wb_data_q <= alu_result;
                is_st_q   <= (op == OpStr);
                if (op == OpCmp) nzcv_q <= nzcv_in;
            end
            if (ack_seen && !is_st_q) wb_data_q <= mem_rdata;
        end
    end

    always_comb begin
        cpsr_out        = '0;
        cpsr_out[CpsrN] = nzcv_q[3];
        cpsr_out[CpsrZ] = nzcv_q[2];
        cpsr_out[CpsrC] = nzcv_q[1];
        cpsr_out[CpsrV] = nzcv_q[0];
    end

    assign reg_we    = (state_q == StWb);
    assign reg_waddr = rd_q;
    assign reg_wdata = wb_data_q;
    assign pc_we     = (state_q == StFlush);
    assign flush     = (state_q == StFlush);
    assign pc_target = target_q;
    assign mem_we    = is_st_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = st_data_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: directed scenarios plus randomized
// instructions checked against a transaction-level reference model.
module tb_exec_ctrl;

    localparam int DATA_W = 32;
    localparam int TO     = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, in_ready;
    logic              is_alu_op, is_cmp_op, is_jmp_op, is_ld_op, is_str_op, is_proc_op;
    logic [3:0]        rd_num, nzcv_in, reg_waddr;
    logic [DATA_W-1:0] alu_result, rd_val, md32, cpsr_out, reg_wdata, pc_target;
    logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;
    logic              taken, reg_we, pc_we, flush, mem_req, mem_we, mem_ack, mem_err, busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  exp_nzcv;

    exec_ctrl #(.DATA_W(DATA_W), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .is_alu_op(is_alu_op), .is_cmp_op(is_cmp_op), .is_jmp_op(is_jmp_op),
        .is_ld_op(is_ld_op), .is_str_op(is_str_op), .is_proc_op(is_proc_op),
        .rd_num(rd_num), .alu_result(alu_result), .rd_val(rd_val), .nzcv_in(nzcv_in),
        .taken(taken), .md32(md32), .cpsr_out(cpsr_out), .reg_we(reg_we),
        .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .pc_we(pc_we), .pc_target(pc_target),
        .flush(flush), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Class bit order: {ld, str, proc, jmp, cmp, alu}.
    localparam logic [5:0] C_ALU = 6'b000001, C_CMP = 6'b000010, C_JMP = 6'b000100;
    localparam logic [5:0] C_PROC = 6'b001000, C_STR = 6'b010000, C_LD = 6'b100000;

    // 0 nop, 1 alu, 2 cmp, 3 jmp, 4 proc, 5 str, 6 ld
    function automatic int ref_class(input logic [5:0] c);
        for (int i = 5; i >= 0; i--) if (c[i]) return i + 1;
        return 0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        in_valid = 1'b0;
        {is_ld_op, is_str_op, is_proc_op, is_jmp_op, is_cmp_op, is_alu_op} = 6'b0;
    endtask

    task automatic drive(input logic [5:0] cls, input logic [3:0] rd, input logic [31:0] res,
                         input logic [31:0] sd, input logic [31:0] tgt, input logic [3:0] nz,
                         input logic tk);
        in_valid = 1'b1;
        {is_ld_op, is_str_op, is_proc_op, is_jmp_op, is_cmp_op, is_alu_op} = cls;
        rd_num = rd; alu_result = res; rd_val = sd; md32 = tgt; nzcv_in = nz; taken = tk;
    endtask

    task automatic test_reset;
        reset = 1'b1; clear_in(); mem_ack = 1'b0; mem_rdata = '0;
        rd_num = '0; alu_result = '0; rd_val = '0; md32 = '0; nzcv_in = '0; taken = 1'b0;
        tick(); tick();
        reset = 1'b0;
        exp_nzcv = 4'h0;
        n_tests++;
        if ({in_ready, busy, reg_we, pc_we, flush, mem_req, mem_err} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 1000000",
                     {in_ready, busy, reg_we, pc_we, flush, mem_req, mem_err});
        end
        n_tests++;
        if (cpsr_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_cpsr: got %h want 0", cpsr_out);
        end
        n_tests++;
        if ({reg_waddr, reg_wdata, pc_target, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h %h want all 0", reg_waddr, reg_wdata,
                     pc_target, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_alu;
        drive(C_ALU, 4'd5, 32'h1234, 32'h0, 32'h0, 4'h0, 1'b0);
        tick(); clear_in();
        n_tests++;
        if ({reg_we, reg_waddr, reg_wdata, in_ready} !== {1'b1, 4'd5, 32'h1234, 1'b0}) begin
            n_fail++;
            $display("FAIL alu_wb: got we=%b a=%0d d=%h rdy=%b want we=1 a=5 d=1234 rdy=0",
                     reg_we, reg_waddr, reg_wdata, in_ready);
        end
        tick();
        n_tests++;
        if ({reg_we, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL alu_done: got we/rdy=%b want 01", {reg_we, in_ready});
        end
    endtask

    task automatic test_cmp_jmp;
        drive(C_CMP, 4'd0, 32'h0, 32'h0, 32'h0, 4'b0100, 1'b0);
        tick();
        exp_nzcv = 4'b0100;
        n_tests++;
        if ({cpsr_out, in_ready} !== {32'h4, 1'b1}) begin
            n_fail++;
            $display("FAIL cmp_cpsr: got %h rdy=%b want 00000004 rdy=1", cpsr_out, in_ready);
        end
        drive(C_JMP, 4'd0, 32'h0, 32'h0, 32'h40, 4'hf, 1'b1);
        tick(); clear_in();
        n_tests++;
        if ({flush, pc_we, pc_target, cpsr_out} !== {1'b1, 1'b1, 32'h40, 32'h4}) begin
            n_fail++;
            $display("FAIL jmp_flush: got fl=%b pcwe=%b tgt=%h cpsr=%h want 1 1 40 4",
                     flush, pc_we, pc_target, cpsr_out);
        end
        tick();
        n_tests++;
        if ({flush, pc_we, in_ready} !== 3'b001) begin
            n_fail++; $display("FAIL jmp_done: got %b want 001", {flush, pc_we, in_ready});
        end
    endtask

    task automatic test_load;
        int reqs = 0;
        drive(C_LD, 4'd7, 32'h100, 32'h0, 32'h0, 4'h0, 1'b0);
        tick(); clear_in();
        for (int i = 1; i <= 3; i++) begin
            if ({mem_req, mem_we, mem_addr} === {1'b1, 1'b0, 32'h100}) reqs++;
            if (i == 3) begin mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; end
            tick();
        end
        mem_ack = 1'b0;
        n_tests++;
        if (reqs != 3) begin
            n_fail++; $display("FAIL load_req: got %0d good req cycles want 3", reqs);
        end
        n_tests++;
        if ({mem_req, reg_we, reg_waddr, reg_wdata} !== {1'b0, 1'b1, 4'd7, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL load_wb: got req=%b we=%b a=%0d d=%h want 0 1 7 deadbeef",
                     mem_req, reg_we, reg_waddr, reg_wdata);
        end
        tick();
        n_tests++;
        if ({reg_we, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL load_done: got %b want 01", {reg_we, in_ready});
        end
    endtask

    task automatic test_store;
        drive(C_STR, 4'd3, 32'h200, 32'hA5, 32'h0, 4'h0, 1'b0);
        tick(); clear_in();
        n_tests++;
        if ({mem_req, mem_we, mem_wdata, mem_addr} !== {1'b1, 1'b1, 32'hA5, 32'h200}) begin
            n_fail++;
            $display("FAIL store_req: got req=%b we=%b wd=%h ad=%h want 1 1 a5 200",
                     mem_req, mem_we, mem_wdata, mem_addr);
        end
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_tests++;
        if ({mem_req, reg_we, in_ready} !== 3'b001) begin
            n_fail++; $display("FAIL store_done: got %b want 001", {mem_req, reg_we, in_ready});
        end
        tick();
        n_tests++;
        if (reg_we !== 1'b0) begin
            n_fail++; $display("FAIL store_no_wb: got reg_we=%b want 0", reg_we);
        end
    endtask

    task automatic test_reset_mem;
        drive(C_LD, 4'd9, 32'h300, 32'h0, 32'h0, 4'h0, 1'b0);
        tick(); clear_in();
        n_tests++;
        if (mem_req !== 1'b1) begin
            n_fail++; $display("FAIL rstmem_req: got %b want 1", mem_req);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_nzcv = 4'h0;
        n_tests++;
        if ({mem_req, in_ready, cpsr_out} !== {1'b0, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL rstmem_abort: got req=%b rdy=%b cpsr=%h want 0 1 0",
                     mem_req, in_ready, cpsr_out);
        end
        mem_ack = 1'b1; mem_rdata = 32'h13579BDF;
        tick();
        mem_ack = 1'b0;
        tick();
        n_tests++;
        if ({reg_we, busy} !== 2'b00) begin
            n_fail++; $display("FAIL rstmem_late_ack: got we/busy=%b want 00", {reg_we, busy});
        end
    endtask

`ifdef EXEC_MEM_TIMEOUT_EN
    task automatic test_timeout;
        int cnt = 0;
        drive(C_LD, 4'd2, 32'h400, 32'h0, 32'h0, 4'h0, 1'b0);
        tick(); clear_in();
        while (mem_req === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        n_tests++;
        if (cnt != TO) begin
            n_fail++; $display("FAIL timeout_len: got %0d req cycles want %0d", cnt, TO);
        end
        n_tests++;
        if ({mem_err, in_ready, reg_we} !== 3'b110) begin
            n_fail++; $display("FAIL timeout_err: got %b want 110", {mem_err, in_ready, reg_we});
        end
        tick();
        n_tests++;
        if ({mem_err, reg_we} !== 2'b00) begin
            n_fail++; $display("FAIL timeout_pulse: got %b want 00", {mem_err, reg_we});
        end
        // Ack on the very last allowed cycle completes normally.
        drive(C_LD, 4'd4, 32'h404, 32'h0, 32'h0, 4'h0, 1'b0);
        tick(); clear_in();
        for (int i = 1; i <= TO; i++) begin
            if (i == TO) begin mem_ack = 1'b1; mem_rdata = 32'hCAFE0001; end
            tick();
        end
        mem_ack = 1'b0;
        n_tests++;
        if ({reg_we, reg_wdata, mem_err} !== {1'b1, 32'hCAFE0001, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_ack_wins: got we=%b d=%h err=%b want 1 cafe0001 0",
                     reg_we, reg_wdata, mem_err);
        end
        tick();
    endtask
`else
    task automatic test_timeout;
        int good = 0;
        drive(C_STR, 4'd2, 32'h400, 32'h77, 32'h0, 4'h0, 1'b0);
        tick(); clear_in();
        for (int i = 0; i < 2 * TO; i++) begin
            if ({mem_req, mem_err} === 2'b10) good++;
            tick();
        end
        n_tests++;
        if (good != 2 * TO) begin
            n_fail++; $display("FAIL no_timeout: got %0d held cycles want %0d", good, 2 * TO);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_tests++;
        if ({mem_req, mem_err, in_ready} !== 3'b001) begin
            n_fail++; $display("FAIL no_timeout_end: got %b want 001", {mem_req, mem_err, in_ready});
        end
    endtask
`endif

    task automatic test_random;
        logic [5:0]  cls;
        logic [3:0]  rd, nz;
        logic [31:0] res, sd, tgt, rdata;
        logic        tk;
        int          k, d;
        for (int n = 0; n < 300; n++) begin
            for (int g = $urandom_range(0, 1); g > 0; g--) begin
                mem_ack = 1'($urandom_range(0, 1));
                tick();
            end
            if ($urandom_range(0, 1) == 1) cls = 6'(1 << $urandom_range(0, 5));
            else cls = 6'($urandom_range(0, 63));
            rd = 4'($urandom); nz = 4'($urandom); tk = 1'($urandom);
            res = $urandom; sd = $urandom; tgt = $urandom; rdata = $urandom;
            k = ref_class(cls);
            mem_ack = 1'($urandom_range(0, 1));
            drive(cls, rd, res, sd, tgt, nz, tk);
            tick(); clear_in();
            mem_ack = 1'b0;
            if (k == 0 || k == 2 || (k == 3 && !tk)) begin
                if (k == 2) exp_nzcv = nz;
                n_tests++;
                if ({busy, reg_we, pc_we, flush, mem_req} !== 5'b0) begin
                    n_fail++;
                    $display("FAIL rnd_noeffect[%0d]: cls=%b got %b want 00000", n, cls,
                             {busy, reg_we, pc_we, flush, mem_req});
                end
            end else if (k == 1) begin
                n_tests++;
                if ({reg_we, reg_waddr, reg_wdata, pc_we, mem_req} !== {1'b1, rd, res, 2'b00}) begin
                    n_fail++;
                    $display("FAIL rnd_alu[%0d]: got we=%b a=%0d d=%h want 1 %0d %h", n,
                             reg_we, reg_waddr, reg_wdata, rd, res);
                end
                tick();
            end else if (k == 3 || k == 4) begin
                n_tests++;
                if ({pc_we, flush, pc_target, reg_we, mem_req} !== {2'b11, tgt, 2'b00}) begin
                    n_fail++;
                    $display("FAIL rnd_flush[%0d]: got pcwe=%b fl=%b tgt=%h want 1 1 %h", n,
                             pc_we, flush, pc_target, tgt);
                end
                tick();
            end else begin
                d = $urandom_range(1, 6);
                for (int i = 1; i <= d; i++) begin
                    n_tests++;
                    if ({mem_req, mem_we, mem_addr} !== {1'b1, (k == 5), res} ||
                        (k == 5 && mem_wdata !== sd)) begin
                        n_fail++;
                        $display("FAIL rnd_memreq[%0d]: got req=%b we=%b ad=%h wd=%h want 1 %0d %h %h",
                                 n, mem_req, mem_we, mem_addr, mem_wdata, (k == 5), res, sd);
                    end
                    if (i == d) begin mem_ack = 1'b1; mem_rdata = rdata; end
                    tick();
                end
                mem_ack = 1'b0;
                n_tests++;
                if (k == 6) begin
                    if ({reg_we, reg_waddr, reg_wdata, mem_req} !== {1'b1, rd, rdata, 1'b0}) begin
                        n_fail++;
                        $display("FAIL rnd_load[%0d]: got we=%b a=%0d d=%h req=%b want 1 %0d %h 0",
                                 n, reg_we, reg_waddr, reg_wdata, mem_req, rd, rdata);
                    end
                    tick();
                end else if ({reg_we, mem_req, busy} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL rnd_store[%0d]: got we/req/busy=%b want 000", n,
                             {reg_we, mem_req, busy});
                end
            end
            n_tests++;
            if ({cpsr_out, in_ready} !== {28'd0, exp_nzcv, 1'b1}) begin
                n_fail++;
                $display("FAIL rnd_cpsr[%0d]: got %h rdy=%b want %h rdy=1", n, cpsr_out,
                         in_ready, {28'd0, exp_nzcv});
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_cmp_jmp();
        test_load();
        test_store();
        test_reset_mem();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/exec_ctrl.md
Name: exec_ctrl

Overview:
- Sequencing controller wrapped around the execute datapath (ALU, comparator, condition checker, sign extenders).
- Accepts one decoded instruction at a time over a valid/ready handshake and owns the architectural CPSR flag register.
- Schedules the outcome of each instruction class: register writeback for ALU ops, flag update for compares, PC redirect and flush for taken jumps, and a multi-cycle memory request/acknowledge sequence for loads and stores.
- Sits between decode and the register file / PC / data-memory port.

Parameters:
- DATA_W, 32, width of datapath values, addresses and PC.
- MEM_TIMEOUT, 15, maximum cycles spent in MEM_WAIT before abort (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  controller can accept (high only in IDLE)
- is_alu_op, is_cmp_op, is_jmp_op, is_ld_op, is_str_op, is_proc_op  in  1 each  instruction class
- rd_num  in  4  destination register number
- alu_result  in  DATA_W  ALU output; this is the effective address for ld/str
- rd_val  in  DATA_W  store data
- nzcv_in  in  4  comparator flags
- taken  in  1  condition-checker result
- md32  in  DATA_W  sign-extended jump target
- cpsr_out  out  DATA_W  {28'd0, nzcv_q}, fed back to the condition checker
- reg_we  out  1  one-cycle register-file write pulse
- reg_waddr  out  4  write address
- reg_wdata  out  DATA_W  write data
- pc_we  out  1  one-cycle PC load pulse
- pc_target  out  DATA_W  new PC
- flush  out  1  one-cycle upstream flush pulse
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = store
- mem_addr  out  DATA_W  address
- mem_wdata  out  DATA_W  store data
- mem_ack  in  1  memory done
- mem_rdata  in  DATA_W  load data
- mem_err  out  1  timeout abort pulse
- busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high, dominant over every other event):
  - state = IDLE; nzcv_q = 0.
  - All pulse outputs = 0; mem_req = 0; mem_addr, mem_wdata, reg_waddr, reg_wdata and pc_target = 0.
  - An outstanding memory access is abandoned: mem_req drops on the cycle after reset is sampled.
- Accept occurs when in_valid && in_ready. Operands are captured into holding registers on the accept cycle.
- Class priority when more than one class bit is set: ld > str > proc > jmp > cmp > alu. No class bit set = NOP: consumed, no side effects.
- States: IDLE, WB, MEM_WAIT, FLUSH.
- IDLE, on accept:
  - alu -> WB.
  - cmp -> nzcv_q <= nzcv_in; stay IDLE.
  - jmp with taken = 1 -> FLUSH.
  - jmp with taken = 0 -> stays IDLE, no effect.
  - proc -> FLUSH unconditionally.
  - ld/str -> MEM_WAIT, with mem_req = 1 from the next cycle.
- WB: reg_we = 1 for exactly one cycle with the captured rd_num and data (ALU result, or mem_rdata for loads); then -> IDLE.
- FLUSH: pc_we = 1 and flush = 1 for one cycle, pc_target = captured md32; then -> IDLE.
- MEM_WAIT:
  - mem_req held high; mem_addr, mem_we and mem_wdata stable.
  - On mem_ack: mem_req drops the next cycle. Load -> WB with mem_rdata captured. Store -> IDLE.
  - mem_ack in any other state is ignored.
- Latency from the accept cycle N:
  - alu: reg_we at N+1.
  - cmp: cpsr_out updates at N+1.
  - taken jmp: flush at N+1.
  - ld/str: mem_req at N+1; with ack at cycle A, load reg_we at A+1 and in_ready at A+2.
- Back-to-back: a cmp followed by a jmp on the next cycle sees the updated cpsr_out, because the cmp leaves the controller in IDLE.
- in_ready is combinational on state only.

Optional Feature:
- Macro EXEC_MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to MEM_WAIT.
  - If the count reaches MEM_TIMEOUT without ack: mem_err pulses one cycle, mem_req drops, no writeback, state -> IDLE.
  - An ack arriving in the same cycle as the timeout wins (normal completion).
- Undefined: MEM_WAIT waits indefinitely; mem_err is tied 0.

Decomposition:
- Shared package exec_pkg holds:
  - the state enum (IDLE, WB, MEM_WAIT, FLUSH);
  - the op-class priority encoding;
  - CPSR field constants: N = 3, Z = 2, C = 1, V = 0.
- One natural sub-module: exec_mem_seq (MEM_WAIT request/ack/timeout logic).

Test Plan:
- Reset, then ALU op with rd = 5 and alu_result = 32'h1234: reg_we is high one cycle later with waddr = 5 and wdata = 32'h1234; in_ready is low for exactly one cycle.
- cmp with nzcv_in = 4'b0100, then jmp on the next cycle with taken = 1 and md32 = 32'h40: cpsr_out = 32'h4; flush and pc_we are high one cycle with pc_target = 32'h40.
- Load with alu_result = 32'h100, ack after 3 cycles with mem_rdata = 32'hDEADBEEF: mem_req is high for 3 cycles with mem_we = 0; then reg_we writes 32'hDEADBEEF.
- Store with rd_val = 32'hA5: mem_we = 1 and mem_wdata = 32'hA5; no reg_we follows.
- reset asserted in MEM_WAIT: mem_req = 0 the next cycle; a later ack produces no writeback.
- With EXEC_MEM_TIMEOUT_EN defined and no ack: mem_err pulses after 15 cycles in MEM_WAIT; the controller returns to IDLE.
